// File: rtl/proc_io_fifo_bank.sv
// Per-channel FIFO front end between the processor I/O port and external valid/ready streams.
// Core reads return data one cycle after req_in; input/output FIFOs backpressure via in_ready/out_valid.

// Single-clock FIFO: push refused when full, pop ignored when empty, head is combinational.
// Zero-latency head; push while full is dropped even if a pop happens in the same cycle.
module proc_io_fifo #(
  parameter int W = 16,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(D));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      // Full/empty come from the pre-edge count, so push+pop together leaves count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Bank of input and output FIFOs with sticky per-channel underflow/overflow flags.
// io_in updates one cycle after a read strobe; in_ready/out_valid are forced low during reset.
module proc_io_fifo_bank #(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUIOIN*NUBITS-1:0]   in_data,
  input  logic [NUIOIN-1:0]          in_valid,
  output logic [NUIOIN-1:0]          in_ready,
  input  logic                       req_in,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  output logic [NUBITS-1:0]          io_in,
  input  logic                       out_en,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic [NUBITS-1:0]          io_out,
  output logic [NUIOOU*NUBITS-1:0]   out_data,
  output logic [NUIOOU-1:0]          out_valid,
  input  logic [NUIOOU-1:0]          out_ready,
  input  logic                       err_clr,
  output logic [NUIOIN-1:0]          err_udf,
  output logic [NUIOOU-1:0]          err_ovf
);
  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);
  localparam logic [AIW:0] NIN_L = (AIW+1)'(NUIOIN);

  logic [NUBITS-1:0] in_head [NUIOIN];
  logic [NUIOIN-1:0] in_full;
  logic [NUIOIN-1:0] in_empty;
  logic [NUIOIN-1:0] in_pop;
  logic [NUIOIN-1:0] udf_set;
  logic [NUBITS-1:0] out_head [NUIOOU];
  logic [NUIOOU-1:0] out_full;
  logic [NUIOOU-1:0] out_empty;
  logic [NUIOOU-1:0] out_push;
  logic [NUIOOU-1:0] ovf_set;
  logic [NUBITS-1:0] sel_head;
  logic              sel_empty;
  logic              addr_ok;

  assign addr_ok = ({1'b0, addr_in} < NIN_L);

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    assign in_ready[k] = rst & ~in_full[k];
    assign in_pop[k]   = rst & req_in & (addr_in == AIW'(k));
    assign udf_set[k]  = req_in & (addr_in == AIW'(k)) & in_empty[k];

    proc_io_fifo #(.W(NUBITS), .D(FDEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (in_valid[k] & in_ready[k]),
      .pop      (in_pop[k]),
      .push_dat (in_data[k*NUBITS +: NUBITS]),
      .head     (in_head[k]),
      .full     (in_full[k]),
      .empty    (in_empty[k])
    );
  end

  for (genvar k = 0; k < NUIOOU; k++) begin : g_out
    assign out_valid[k] = rst & ~out_empty[k];
    assign out_push[k]  = rst & out_en & (addr_out == AOW'(k));
    assign ovf_set[k]   = out_en & (addr_out == AOW'(k)) & out_full[k];
    assign out_data[k*NUBITS +: NUBITS] = out_head[k];

    proc_io_fifo #(.W(NUBITS), .D(FDEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (out_push[k]),
      .pop      (out_valid[k] & out_ready[k]),
      .push_dat (io_out),
      .head     (out_head[k]),
      .full     (out_full[k]),
      .empty    (out_empty[k])
    );
  end

  always_comb begin
    sel_head  = '0;
    sel_empty = 1'b1;
    for (int k = 0; k < NUIOIN; k++) begin
      if (addr_in == AIW'(k)) begin
        sel_head  = in_head[k];
        sel_empty = in_empty[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      io_in   <= '0;
      err_udf <= '0;
      err_ovf <= '0;
    end else begin
      if (req_in) begin
        if (!addr_ok)        io_in <= '0;
        else if (!sel_empty) io_in <= sel_head;
      end
      // A new error in the same cycle as err_clr wins.
      err_udf <= (err_clr ? {NUIOIN{1'b0}} : err_udf) | udf_set;
      err_ovf <= (err_clr ? {NUIOOU{1'b0}} : err_ovf) | ovf_set;
    end
  end
endmodule

// File: tb/tb_proc_io_fifo_bank.sv
// Directed bench for proc_io_fifo_bank with hand-computed expected values.
module tb_proc_io_fifo_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic        req_in;
  logic        addr_in;
  logic [15:0] io_in;
  logic        out_en;
  logic        addr_out;
  logic [15:0] io_out;
  logic [31:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic        err_clr;
  logic [1:0]  err_udf;
  logic [1:0]  err_ovf;

  int checks   = 0;
  int failures = 0;

  proc_io_fifo_bank dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req_in    (req_in),
    .addr_in   (addr_in),
    .io_in     (io_in),
    .out_en    (out_en),
    .addr_out  (addr_out),
    .io_out    (io_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_udf   (err_udf),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with every strobe active
    rst = 1'b0; in_data = 32'h1111_2222; in_valid = 2'b11; req_in = 1'b1; addr_in = 1'b0;
    out_en = 1'b1; addr_out = 1'b0; io_out = 16'h1234; out_ready = 2'b11; err_clr = 1'b0;
    tick(); tick(); tick();
    chk("rst_in_ready", in_ready, 2'b00);
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_io_in", io_in, 16'h0000);
    chk("rst_err_udf", err_udf, 2'b00);
    chk("rst_err_ovf", err_ovf, 2'b00);
    in_valid = 2'b00; req_in = 1'b0; out_en = 1'b0; out_ready = 2'b00;
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 2'b11);
    chk("post_rst_out_valid", out_valid, 2'b00);

    // Input fill/drain on ch1
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) chk("in_ready1_before_8th", in_ready, 2'b11);
      in_data = {16'h0100 + 16'(i), 16'h0000};
      in_valid = 2'b10;
      tick();
    end
    in_valid = 2'b00;
    chk("in_ready_ch1_full", in_ready, 2'b01);
    req_in = 1'b1; addr_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("drain_ch1", io_in, 16'h0100 + 16'(i));
    end
    req_in = 1'b0;
    chk("in_ready_after_drain", in_ready, 2'b11);
    chk("no_udf_after_drain", err_udf, 2'b00);

    // Underflow on ch0 with simultaneous push (no bypass)
    in_data = 32'h0000_00AA; in_valid = 2'b01; req_in = 1'b1; addr_in = 1'b0;
    tick();
    in_valid = 2'b00;
    chk("udf_flag", err_udf, 2'b01);
    chk("udf_io_in_held", io_in, 16'h0108);
    tick();
    req_in = 1'b0;
    chk("read_after_udf", io_in, 16'h00AA);
    chk("udf_sticky", err_udf, 2'b01);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("udf_cleared", err_udf, 2'b00);
    req_in = 1'b1; addr_in = 1'b0; err_clr = 1'b1;
    tick();
    req_in = 1'b0;
    chk("udf_set_beats_clr", err_udf, 2'b01);
    chk("udf_io_in_held2", io_in, 16'h00AA);
    tick();
    err_clr = 1'b0;
    chk("udf_cleared2", err_udf, 2'b00);

    // Output overflow on ch0
    out_ready = 2'b00; out_en = 1'b1; addr_out = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      io_out = 16'h0200 + 16'(i);
      tick();
      if (i == 8) chk("no_ovf_at_8", err_ovf, 2'b00);
    end
    out_en = 1'b0;
    chk("ovf_flag", err_ovf, 2'b01);
    chk("ovf_out_valid", out_valid, 2'b01);
    tick();
    chk("head_stable_not_ready", out_data[15:0], 16'h0201);
    out_ready = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      chk("out_ch0_valid", out_valid[0], 1'b1);
      chk("out_ch0_data", out_data[15:0], 16'h0200 + 16'(i));
      tick();
    end
    out_ready = 2'b00;
    chk("out_ch0_empty", out_valid, 2'b00);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared", err_ovf, 2'b00);

    // Simultaneous write and pop on ch1 at count 3, wrapping pointers over 20 words
    out_en = 1'b1; addr_out = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      io_out = 16'h0300 + 16'(j);
      tick();
    end
    out_ready = 2'b10;
    for (int j = 4; j <= 20; j++) begin
      io_out = 16'h0300 + 16'(j);
      chk("simul_head", out_data[31:16], 16'h0300 + 16'(j - 3));
      tick();
    end
    out_en = 1'b0;
    for (int j = 18; j <= 20; j++) begin
      chk("simul_drain_valid", out_valid, 2'b10);
      chk("simul_drain", out_data[31:16], 16'h0300 + 16'(j));
      tick();
    end
    out_ready = 2'b00;
    chk("simul_empty", out_valid, 2'b00);
    chk("simul_no_ovf", err_ovf, 2'b00);

    // Cross-channel interleave
    for (int i = 1; i <= 4; i++) begin
      in_valid = (i <= 3) ? 2'b11 : 2'b00;
      in_data = {16'h0B00 + 16'(i), 16'h0A00 + 16'(i)};
      out_en = 1'b1; addr_out = 1'((i - 1) % 2); io_out = 16'h0C00 + 16'(i);
      tick();
    end
    in_valid = 2'b00; out_en = 1'b0;
    req_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr_in = 1'(i % 2);
      tick();
      chk("xch_read", io_in, (i % 2 == 0) ? 16'h0A01 + 16'(i / 2) : 16'h0B01 + 16'(i / 2));
    end
    req_in = 1'b0;
    chk("xch_no_udf", err_udf, 2'b00);
    chk("xch_out0_a", out_data[15:0], 16'h0C01);
    chk("xch_out1_a", out_data[31:16], 16'h0C02);
    out_ready = 2'b11;
    tick();
    chk("xch_out0_b", out_data[15:0], 16'h0C03);
    chk("xch_out1_b", out_data[31:16], 16'h0C04);
    tick();
    out_ready = 2'b00;
    chk("xch_out_empty", out_valid, 2'b00);
    chk("xch_in_ready", in_ready, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
